// File: rtl/sat_rr_sched.sv
// Round-robin scheduler sharing one signed N->K saturation stage among R requesters.
// Latency: 1 cycle. A sample granted at edge t is on o_data with o_valid high in cycle t+1.
// Backpressure: while i_ready=0 and the result register is full, o_gnt=0 and the result holds.
// Optional build macro SAT_CNT_CLR_EN adds i_cnt_clr, a synchronous clear of o_sat_cnt.
module sat_rr_sched #(
    parameter int N     = 5,
    parameter int K     = 3,
    parameter int R     = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [R-1:0]         i_req,
    input  logic [R*N-1:0]       i_data,
    output logic [R-1:0]         o_gnt,
    output logic                 o_valid,
    input  logic                 i_ready,
`ifdef SAT_CNT_CLR_EN
    input  logic                 i_cnt_clr,
`endif
    output logic [K-1:0]         o_data,
    output logic [$clog2(R)-1:0] o_id,
    output logic                 o_sat_hi,
    output logic                 o_sat_lo,
    output logic [CNT_W-1:0]     o_sat_cnt
);

    localparam int ID_W = $clog2(R);
    localparam int IW1  = ID_W + 1;

    // Clip thresholds expressed at input width, and the clipped output codes.
    localparam logic signed [N-1:0] SAT_MAX = {{(N-K+1){1'b0}}, {(K-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {{(N-K+1){1'b1}}, {(K-1){1'b0}}};
    localparam logic [K-1:0]        OUT_MAX = {1'b0, {(K-1){1'b1}}};
    localparam logic [K-1:0]        OUT_MIN = {1'b1, {(K-1){1'b0}}};
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;

    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [K-1:0]      data_q, data_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              hi_q, hi_d;
    logic              lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cap_en;
    logic              capture;
    logic [R-1:0]      gnt_oh;
    logic [ID_W-1:0]   gnt_idx;
    logic              found;
    logic [IW1-1:0]    scan_sum;
    logic [ID_W-1:0]   scan_idx;
    logic signed [N-1:0] sel;
    logic              clip_hi;
    logic              clip_lo;
    logic [K-1:0]      sat_dat;
    logic              cnt_clr;

`ifdef SAT_CNT_CLR_EN
    assign cnt_clr = i_cnt_clr;
`else
    assign cnt_clr = 1'b0;
`endif

    // A new sample may be taken when the output register is empty or being drained.
    assign cap_en  = (state_q == IDLE) || i_ready;
    assign capture = cap_en && (|i_req);

    // Rotating-priority search: first set request starting at ptr, wrapping at R-1.
    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < R; i++) begin
            scan_sum = {1'b0, ptr_q} + IW1'(i);
            if (scan_sum >= IW1'(R)) begin
                scan_sum = scan_sum - IW1'(R);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && i_req[scan_idx]) begin
                found            = 1'b1;
                gnt_oh[scan_idx] = 1'b1;
                gnt_idx          = scan_idx;
            end
        end
    end

    // Grant is suppressed while holding under backpressure and while in reset.
    assign o_gnt = (cap_en && rst_n) ? gnt_oh : '0;

    // One-hot select of the winning sample.
    always_comb begin
        sel = '0;
        for (int r = 0; r < R; r++) begin
            if (gnt_oh[r]) begin
                sel = i_data[r*N +: N];
            end
        end
    end

    // Signed saturation over the full input width; at most one clip flag can be set.
    always_comb begin
        clip_hi = (sel > SAT_MAX);
        clip_lo = (sel < SAT_MIN);
        if (clip_hi) begin
            sat_dat = OUT_MAX;
        end else if (clip_lo) begin
            sat_dat = OUT_MIN;
        end else begin
            sat_dat = sel[K-1:0];
        end
    end

    // Next-state, pointer, result register and clip counter update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (i_ready && !capture) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            data_d = sat_dat;
            id_d   = gnt_idx;
            hi_d   = clip_hi;
            lo_d   = clip_lo;
            ptr_d  = (gnt_idx == ID_W'(R-1)) ? '0 : gnt_idx + ID_W'(1);
        end

        // A clear takes priority over an increment on the same edge.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (capture && (clip_hi || clip_lo) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and datapath registers; reset drops any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid   = (state_q == FULL);
    assign o_data    = data_q;
    assign o_id      = id_q;
    assign o_sat_hi  = hi_q;
    assign o_sat_lo  = lo_q;
    assign o_sat_cnt = cnt_q;

endmodule

// File: tb/tb_sat_rr_sched.sv
// Directed bench for sat_rr_sched with a result scoreboard.
// Two instances share stimulus: default widths, and CNT_W=3 for counter saturation.
module tb_sat_rr_sched;

    localparam int N     = 5;
    localparam int K     = 3;
    localparam int R     = 4;
    localparam int CNT_W = 16;
    localparam int IW    = $clog2(R);
    localparam int MAXV  = 2**(K-1) - 1;
    localparam int MINV  = -(2**(K-1));
    localparam int CMAX  = 2**CNT_W - 1;
    localparam int CMAX3 = 7;
`ifdef SAT_CNT_CLR_EN
    localparam bit HAS_CLR = 1'b1;
`else
    localparam bit HAS_CLR = 1'b0;
`endif

    typedef struct packed {
        logic [K-1:0]  d;
        logic [IW-1:0] id;
        logic          hi;
        logic          lo;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [R-1:0]        req;
    logic                ready;
    logic                clr;
    logic signed [N-1:0] samp [R];
    logic [R*N-1:0]      data;

    logic [R-1:0]        o_gnt,  g3;
    logic                o_valid, v3;
    logic [K-1:0]        o_data, d3;
    logic [IW-1:0]       o_id,   id3;
    logic                o_sat_hi, hi3;
    logic                o_sat_lo, lo3;
    logic [CNT_W-1:0]    o_sat_cnt;
    logic [2:0]          c3;

    always_comb begin
        data = '0;
        for (int r = 0; r < R; r++) data[r*N +: N] = samp[r];
    end

    sat_rr_sched #(.N(N), .K(K), .R(R), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_data(data), .o_gnt(o_gnt),
        .o_valid(o_valid), .i_ready(ready),
`ifdef SAT_CNT_CLR_EN
        .i_cnt_clr(clr),
`endif
        .o_data(o_data), .o_id(o_id), .o_sat_hi(o_sat_hi), .o_sat_lo(o_sat_lo),
        .o_sat_cnt(o_sat_cnt)
    );

    sat_rr_sched #(.N(N), .K(K), .R(R), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_req(req), .i_data(data), .o_gnt(g3),
        .o_valid(v3), .i_ready(ready),
`ifdef SAT_CNT_CLR_EN
        .i_cnt_clr(clr),
`endif
        .o_data(d3), .o_id(id3), .o_sat_hi(hi3), .o_sat_lo(lo3),
        .o_sat_cnt(c3)
    );

    int           errors = 0;
    int           checks = 0;
    res_t         sb [$];
    bit           mfull;
    int           mptr;
    int           mcnt;
    int           mcnt3;
    logic [R-1:0] last_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t sat_model(input int s, input int id);
        res_t        r;
        logic [31:0] sv;
        r.id = IW'(id);
        r.hi = 1'b0;
        r.lo = 1'b0;
        if (s > MAXV) begin
            sv   = MAXV;
            r.hi = 1'b1;
        end else if (s < MINV) begin
            sv   = MINV;
            r.lo = 1'b1;
        end else begin
            sv = s;
        end
        r.d = sv[K-1:0];
        return r;
    endfunction

    function automatic int exp_winner(input logic [R-1:0] rq);
        for (int i = 0; i < R; i++) begin
            int j;
            j = (mptr + i) % R;
            if (rq[j]) return j;
        end
        return -1;
    endfunction

    // One clock of stimulus: drive, check grant and outputs, advance model, clock.
    task automatic step(input logic [R-1:0] rq, input logic rdy, input logic cl);
        logic [R-1:0] eg;
        res_t         e;
        bit           cap;
        int           g;
        int           s;
        req   = rq;
        ready = rdy;
        clr   = cl;
        #1;
        cap = (!mfull || rdy) && (rq != '0);
        g   = cap ? exp_winner(rq) : -1;
        eg  = (g >= 0) ? (R'(1) << g) : '0;
        last_gnt = o_gnt;
        chk("gnt", 64'(o_gnt), 64'(eg));
        chk("gnt3", 64'(g3), 64'(eg));
        chk("valid", 64'(o_valid), 64'(mfull));
        chk("valid3", 64'(v3), 64'(mfull));
        if (mfull && sb.size() > 0) begin
            e = rdy ? sb.pop_front() : sb[0];
            chk("data", 64'(o_data), 64'(e.d));
            chk("id", 64'(o_id), 64'(e.id));
            chk("sat_hi", 64'(o_sat_hi), 64'(e.hi));
            chk("sat_lo", 64'(o_sat_lo), 64'(e.lo));
            chk("result3", 64'({d3, id3, hi3, lo3}), 64'(e));
        end
        chk("cnt", 64'(o_sat_cnt), 64'(mcnt));
        chk("cnt3", 64'(c3), 64'(mcnt3));
        e = '0;
        if (cap) begin
            s = samp[g];
            e = sat_model(s, g);
            sb.push_back(e);
            mptr  = (g + 1) % R;
            mfull = 1'b1;
        end else if (mfull && rdy) begin
            mfull = 1'b0;
        end
        if (HAS_CLR && cl) begin
            mcnt  = 0;
            mcnt3 = 0;
        end else if (cap && (e.hi || e.lo)) begin
            if (mcnt < CMAX) mcnt++;
            if (mcnt3 < CMAX3) mcnt3++;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        req   = '1;
        ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_data", 64'(o_data), 64'(0));
        chk("rst_id", 64'(o_id), 64'(0));
        chk("rst_hi", 64'(o_sat_hi), 64'(0));
        chk("rst_lo", 64'(o_sat_lo), 64'(0));
        chk("rst_cnt", 64'(o_sat_cnt), 64'(0));
        chk("rst_cnt3", 64'(c3), 64'(0));
        chk("rst_gnt", 64'(o_gnt), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = '0;
        mfull = 1'b0;
        mptr  = 0;
        mcnt  = 0;
        mcnt3 = 0;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        clr   = 1'b0;
        mfull = 1'b0;
        mptr  = 0;
        mcnt  = 0;
        mcnt3 = 0;
        for (int r = 0; r < R; r++) samp[r] = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Single-channel sweep over the whole signed input range.
        for (int v = 1; v <= 15; v++) begin
            samp[0] = N'(v);
            step(4'b0001, 1'b1, 1'b0);
        end
        samp[0] = '0;
        step(4'b0001, 1'b1, 1'b0);
        for (int v = -1; v >= -16; v--) begin
            samp[0] = N'(v);
            step(4'b0001, 1'b1, 1'b0);
        end
        step(4'b0000, 1'b1, 1'b0);
        chk("sweep_cnt", 64'(o_sat_cnt), 64'(24));
        chk("sweep_cnt3", 64'(c3), 64'(7));
        chk("sweep_idle", 64'(o_valid), 64'(0));

        // Fairness with all requesters active from a fresh pointer.
        do_reset();
        for (int r = 0; r < R; r++) samp[r] = N'(r * 3 - 5);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            chk("fair_order", 64'(last_gnt), 64'(R'(1) << (i % R)));
        end

        // Pointer wrap: after requester 3, requester 0 outranks 3.
        step(4'b1000, 1'b1, 1'b0);
        chk("wrap_g3", 64'(last_gnt), 64'(4'b1000));
        step(4'b1001, 1'b1, 1'b0);
        chk("wrap_g0", 64'(last_gnt), 64'(4'b0001));
        step(4'b1001, 1'b1, 1'b0);
        chk("wrap_g3b", 64'(last_gnt), 64'(4'b1000));
        step(4'b0000, 1'b1, 1'b0);

        // Backpressure: result held stable and no grant while i_ready is low.
        samp[1] = 5'sd2;
        step(4'b0010, 1'b1, 1'b0);
        samp[1] = -5'sd3;
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 1'b0, 1'b0);
            chk("bp_nogrant", 64'(last_gnt), 64'(0));
            chk("bp_data", 64'(o_data), 64'(3'd2));
            chk("bp_id", 64'(o_id), 64'(1));
        end
        step(4'b0010, 1'b1, 1'b0);
        chk("bp_release", 64'(last_gnt), 64'(4'b0010));
        step(4'b0000, 1'b1, 1'b0);

        // Counter saturation on the narrow-counter instance.
        do_reset();
        samp[2] = 5'sd9;
        for (int i = 0; i < 10; i++) step(4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        chk("cnt3_stick", 64'(c3), 64'(7));
        chk("cnt_ten", 64'(o_sat_cnt), 64'(10));
`ifdef SAT_CNT_CLR_EN
        step(4'b0100, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b0);
        chk("clr_wins", 64'(o_sat_cnt), 64'(0));
        chk("clr_wins3", 64'(c3), 64'(0));
`endif

        // Reset while holding a clipped result with the pointer at 2.
        do_reset();
        samp[1] = 5'sd9;
        step(4'b0010, 1'b1, 1'b0);
        chk("pre_rst_data", 64'(o_data), 64'(3'd3));
        chk("pre_rst_valid", 64'(o_valid), 64'(1));
        do_reset();
        for (int r = 0; r < R; r++) samp[r] = N'(r);
        step(4'b1111, 1'b1, 1'b0);
        chk("post_rst_gnt", 64'(last_gnt), 64'(4'b0001));
        step(4'b0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
